// File: rtl/wavegen_dds.sv
// Direct-digital-synthesis waveform generator: phase accumulator, shaper, amplitude scaler.
// Define WAVEGEN_SINE_EN to build the parabolic sine and rectified modes (3-5).
module wavegen_dds #(
   parameter int W       = 8,
   parameter int PHASE_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [2:0]         cfg_mode,
   input  logic [PHASE_W-1:0] cfg_ftw,
   input  logic [W-1:0]       cfg_duty,
   input  logic [W-1:0]       cfg_amp,
   output logic [W-1:0]       waveform,
   output logic               out_valid,
   output logic               phase_wrap
);

   localparam int W2 = 2 * W;
   localparam logic [W-1:0] MAX  = {W{1'b1}};
   localparam logic [W-1:0] MID  = {1'b1, {(W-1){1'b0}}};
   localparam logic [W-1:0] ZERO = {W{1'b0}};
   localparam logic [W:0]   ONE  = {{W{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [PHASE_W-1:0] phase;
   logic [PHASE_W:0]   sum;
   logic               carry;
   logic               accept;
   logic               load_direct, load_shadow, commit;
   logic               en_d1;

   logic [2:0]         mode_act, mode_sh;
   logic [PHASE_W-1:0] ftw_act, ftw_sh;
   logic [W-1:0]       duty_act, duty_sh;
   logic [W-1:0]       amp_act, amp_sh;

   logic [W-1:0]       s, t;
   logic               h;
   logic [W-1:0]       raw_nxt, raw, amp_pipe;
   logic [W:0]         amp_inc;
   logic [W2-1:0]      scaled;

   assign sum    = {1'b0, phase} + {1'b0, ftw_act};
   assign carry  = en & sum[PHASE_W];
   assign accept = cfg_valid & cfg_ready;

   // Config FSM: direct writes while stopped, shadowed writes committed at phase wrap while running.
   always_comb begin
      state_nxt   = state;
      load_direct = 1'b0;
      load_shadow = 1'b0;
      commit      = 1'b0;
      case (state)
         IDLE: begin
            load_direct = accept;
            if (en) state_nxt = RUN;
            else    state_nxt = IDLE;
         end
         RUN: begin
            if (!en) begin
               load_direct = accept;
               state_nxt   = IDLE;
            end else if (accept) begin
               load_shadow = 1'b1;
               state_nxt   = PEND;
            end else begin
               state_nxt = RUN;
            end
         end
         PEND: begin
            if (!en) begin
               commit    = 1'b1;
               state_nxt = IDLE;
            end else if (carry) begin
               commit    = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = PEND;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cfg_ready <= 1'b1;
      end else begin
         state     <= state_nxt;
         cfg_ready <= (state_nxt != PEND);
      end
   end

   // Active configuration; the shadow is only ever copied here, never read by the datapath.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_act <= 3'd0;
         ftw_act  <= {PHASE_W{1'b0}};
         duty_act <= MID;
         amp_act  <= MAX;
      end else if (load_direct) begin
         mode_act <= cfg_mode;
         ftw_act  <= cfg_ftw;
         duty_act <= cfg_duty;
         amp_act  <= cfg_amp;
      end else if (commit) begin
         mode_act <= mode_sh;
         ftw_act  <= ftw_sh;
         duty_act <= duty_sh;
         amp_act  <= amp_sh;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_sh <= 3'd0;
         ftw_sh  <= {PHASE_W{1'b0}};
         duty_sh <= ZERO;
         amp_sh  <= ZERO;
      end else if (load_shadow) begin
         mode_sh <= cfg_mode;
         ftw_sh  <= cfg_ftw;
         duty_sh <= cfg_duty;
         amp_sh  <= cfg_amp;
      end
   end

   // Stage 1: phase accumulator and wrap pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase      <= {PHASE_W{1'b0}};
         phase_wrap <= 1'b0;
         en_d1      <= 1'b0;
         out_valid  <= 1'b0;
      end else begin
         if (en) phase <= sum[PHASE_W-1:0];
         phase_wrap <= carry;
         en_d1      <= en;
         out_valid  <= en_d1;
      end
   end

   assign s = phase[PHASE_W-1 -: W];
   assign t = phase[PHASE_W-2 -: W];
   assign h = phase[PHASE_W-1];

`ifdef WAVEGEN_SINE_EN
   logic [W2-1:0] prod;
   logic [W-1:0]  p, p_dbl, sine_val;
   localparam logic [W-1:0] MID_M1 = {1'b0, {(W-1){1'b1}}};

   // Parabolic half-cycle approximation; p peaks just below MID so p<<1 never overflows.
   always_comb begin
      prod  = W2'(t) * W2'(MAX - t);
      p     = W'(prod >> (W - 1));
      p_dbl = W'({p, 1'b0});
      if (h) sine_val = MID_M1 - p;
      else   sine_val = MID + p;
   end
`endif

   always_comb begin
      raw_nxt = ZERO;
      case (mode_act)
         3'd0:    raw_nxt = (s < duty_act) ? MAX : ZERO;
         3'd1:    raw_nxt = s;
         3'd2:    raw_nxt = h ? ~t : t;
`ifdef WAVEGEN_SINE_EN
         3'd3:    raw_nxt = sine_val;
         3'd4:    raw_nxt = p_dbl;
         3'd5:    raw_nxt = h ? ZERO : p_dbl;
`endif
         default: raw_nxt = ZERO;
      endcase
   end

   // Amplitude travels with its sample so a commit changes mode and amp on the same output cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         raw      <= ZERO;
         amp_pipe <= MAX;
      end else if (en) begin
         raw      <= raw_nxt;
         amp_pipe <= amp_act;
      end
   end

   always_comb begin
      amp_inc = {1'b0, amp_pipe} + ONE;
      scaled  = W2'(raw) * W2'(amp_inc);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         waveform <= ZERO;
      end else if (en_d1) begin
         waveform <= W'(scaled >> W);
      end
   end

endmodule
